// File: rtl/ps2_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_decoder
// Brief    : PS/2 device-to-host deframer with E0/F0 prefix folding into key
//            events. Optional clock glitch filter: define PS2_RX_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TO_PRE = c_TW'(TIMEOUT_CYCLES - 2);
  localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic            w_clk_s;
  logic            w_dat_s;
  logic            w_clk_lvl;
  logic            r_prev_clk;
  logic            w_fall;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [c_TW-1:0] r_to_cnt;
  logic            w_timeout;
  logic            w_shift_en;
  logic            w_par_en;
  logic            w_done;
  logic            r_accept;
  logic            r_par_bad;
  logic            r_stop_bad;
  logic            r_ext_pend;
  logic            r_brk_pend;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

`ifdef PS2_RX_FILTER_EN
  localparam int c_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [c_FW-1:0] r_flt_cnt;
  logic            r_flt_lvl;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_flt_cnt <= '0;
      r_flt_lvl <= 1'b0;
    end else if (w_clk_s == r_flt_lvl) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == c_FW'(FILTER_LEN - 1)) begin
      r_flt_cnt <= '0;
      r_flt_lvl <= w_clk_s;
    end else begin
      r_flt_cnt <= r_flt_cnt + c_FW'(1);
    end
  end

  assign w_clk_lvl = r_flt_lvl;
`else
  assign w_clk_lvl = w_clk_s;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_prev_clk <= 1'b0;
    else       r_prev_clk <= w_clk_lvl;
  end

  assign w_fall    = r_prev_clk & ~w_clk_lvl;
  assign w_timeout = (r_state != IDLE) && (r_to_cnt == c_TO_PRE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Timeout wins over a coincident falling edge.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_done      = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fall && !w_dat_s) w_state_nxt = DATA;
        end
        DATA: begin
          if (w_fall) begin
            w_shift_en = 1'b1;
            if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
          end
        end
        PARITY: begin
          if (w_fall) begin
            w_par_en    = 1'b1;
            w_state_nxt = STOP;
          end
        end
        STOP: begin
          if (w_fall) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_accept   <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
    end else begin
      if (r_state == IDLE)  r_bit_cnt <= '0;
      else if (w_shift_en)  r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en)       r_shift[r_bit_cnt] <= w_dat_s;
      if (w_par_en)         r_parity <= w_dat_s;
      if ((r_state == IDLE) || w_fall) r_to_cnt <= '0;
      else if (r_to_cnt != c_TO_MAX)   r_to_cnt <= r_to_cnt + c_TW'(1);
      r_accept   <= w_done &  w_dat_s &  (^{r_shift, r_parity});
      r_par_bad  <= w_done &  w_dat_s & ~(^{r_shift, r_parity});
      r_stop_bad <= w_done & ~w_dat_s;
    end
  end

  // Output stage: the extra register sets the 3-cycle stop-to-valid latency.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
    end else begin
      byte_valid <= r_accept;
      key_valid  <= 1'b0;
      parity_err <= r_par_bad;
      frame_err  <= r_stop_bad | w_timeout;
      if (r_stop_bad || r_par_bad || w_timeout) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
      if (r_accept) begin
        byte_data <= r_shift;
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          key_code     <= r_shift;
          key_extended <= r_ext_pend;
          key_release  <= r_brk_pend;
          key_valid    <= 1'b1;
          r_ext_pend   <= 1'b0;
          r_brk_pend   <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_decoder
// Brief    : Directed self-checking bench for ps2_rx_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_decoder;

  localparam int c_TO  = 300;
  localparam int c_FLT = 8;
`ifdef PS2_RX_FILTER_EN
  localparam int c_FDLY = c_FLT;
`else
  localparam int c_FDLY = 0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_extended;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int e0 = 0;
  int n_bv = 0, n_kv = 0, n_pe = 0, n_fe = 0, n_busy = 0;
  int b_bv, b_kv, b_pe, b_fe, b_busy;
  int bv_cyc = 0, kv_cyc = 0, fe_cyc = 0;

  ps2_rx_decoder #(.TIMEOUT_CYCLES(c_TO), .FILTER_LEN(c_FLT)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_extended(key_extended),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Count high cycles of each pulse so a stretched pulse shows as an extra count.
  always @(negedge CLOCK_50) begin
    if (byte_valid) begin n_bv++; bv_cyc = cyc; end
    if (key_valid)  begin n_kv++; kv_cyc = cyc; end
    if (parity_err) n_pe++;
    if (frame_err)  begin n_fe++; fe_cyc = cyc; end
    if (busy)       n_busy++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_bv = n_bv; b_kv = n_kv; b_pe = n_pe; b_fe = n_fe; b_busy = n_busy;
  endtask

  // Frame bits LSB first: start, 8 data, parity, stop. e0 is the CLOCK_50
  // edge number that first samples each ps2_clk fall.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (10) @(negedge CLOCK_50);
      e0 = cyc + 1;
      ps2_clk = 1'b0;
      repeat (20) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
      repeat (10) @(negedge CLOCK_50);
    end
    ps2_dat = 1'b1;
    repeat (20) @(negedge CLOCK_50);
  endtask

  initial begin
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check_val("rst_byte_data", 32'(byte_data), 0);
    check_val("rst_key_code", 32'(key_code), 0);
    check_val("rst_flags", 32'({byte_valid, key_valid, key_release, key_extended,
                                 parity_err, frame_err, busy}), 0);
    reset = 1'b0;
    repeat (30) @(negedge CLOCK_50);

    // 0x1C: three ones, parity 0
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_val("t1_byte_data", 32'(byte_data), 32'h1C);
    check_val("t1_n_bv", n_bv - b_bv, 1);
    check_val("t1_n_kv", n_kv - b_kv, 1);
    check_val("t1_key_code", 32'(key_code), 32'h1C);
    check_val("t1_rel_ext", 32'({key_release, key_extended}), 0);
    check_val("t1_busy", 32'(busy), 0);
    check_val("t1_bv_latency", bv_cyc - e0, 3 + c_FDLY);
    check_val("t1_kv_latency", kv_cyc - e0, 3 + c_FDLY);

    // F0 (parity 1), 1C
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_val("t2_n_bv", n_bv - b_bv, 2);
    check_val("t2_n_kv", n_kv - b_kv, 1);
    check_val("t2_key_code", 32'(key_code), 32'h1C);
    check_val("t2_rel_ext", 32'({key_release, key_extended}), 32'b10);

    // E0 (parity 0), F0 (parity 1), 74 (parity 1)
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h74, 1'b1, 1'b1, 11);
    check_val("t3_n_kv", n_kv - b_kv, 1);
    check_val("t3_key_code", 32'(key_code), 32'h74);
    check_val("t3_rel_ext", 32'({key_release, key_extended}), 32'b11);
    send_frame(8'h29, 1'b0, 1'b1, 11);
    check_val("t3_plain_code", 32'(key_code), 32'h29);
    check_val("t3_plain_flags", 32'({key_release, key_extended}), 0);

    // 0x1C with wrong parity, then with a zero stop bit
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check_val("t4_n_pe", n_pe - b_pe, 1);
    check_val("t4_n_bv", n_bv - b_bv, 0);
    check_val("t4_n_kv", n_kv - b_kv, 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check_val("t4_n_fe", n_fe - b_fe, 1);
    check_val("t4_stop_n_pe", n_pe - b_pe, 0);
    check_val("t4_stop_n_bv", n_bv - b_bv, 0);
    check_val("t4_byte_hold", 32'(byte_data), 32'h29);

    // F0 then a bad-parity frame: prefix must be forgotten
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h74, 1'b0, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_val("t4_drop_clears_brk", 32'(key_release), 0);

    // Start + 3 data bits then idle: timeout
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 4);
    repeat (c_TO + 20) @(negedge CLOCK_50);
    check_val("t5_n_fe", n_fe - b_fe, 1);
    check_val("t5_fe_latency", fe_cyc - e0, 2 + c_FDLY + c_TO - 1);
    check_val("t5_busy", 32'(busy), 0);
    check_val("t5_n_bv", n_bv - b_bv, 0);
    send_frame(8'h29, 1'b0, 1'b1, 11);
    check_val("t5_next_code", 32'(key_code), 32'h29);

    // Reset after the 5th bit (start + 4 data bits)
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    check_val("t6_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_val("t6_rst_byte_data", 32'(byte_data), 0);
    check_val("t6_rst_key_code", 32'(key_code), 0);
    check_val("t6_rst_flags", 32'({byte_valid, key_valid, key_release, key_extended,
                                    parity_err, frame_err, busy}), 0);
    reset = 1'b0;
    repeat (c_TO + 20) @(negedge CLOCK_50);
    check_val("t6_no_err", (n_fe - b_fe) + (n_pe - b_pe), 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check_val("t6_n_kv", n_kv - b_kv, 1);
    check_val("t6_key_code", 32'(key_code), 32'h1C);
    check_val("t6_byte_data", 32'(byte_data), 32'h1C);

`ifdef PS2_RX_FILTER_EN
    // 3-cycle low glitch with data low would look like a start bit unfiltered
    snap();
    ps2_dat = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    ps2_clk = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    ps2_clk = 1'b1;
    repeat (30) @(negedge CLOCK_50);
    ps2_dat = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check_val("t7_glitch_busy", n_busy - b_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
